// File: rtl/sp_pkg.sv
// Shared definitions for the multi-cycle SP core: ISA encodings, FSM states,
// ALU operation codes and the decoded-instruction record.
package sp_pkg;

   // Major opcodes (inst[31:26])
   localparam logic [5:0] OP_R    = 6'd0;
   localparam logic [5:0] OP_ANDI = 6'd1;
   localparam logic [5:0] OP_ORI  = 6'd2;
   localparam logic [5:0] OP_ADDI = 6'd3;
   localparam logic [5:0] OP_SUBI = 6'd4;
   localparam logic [5:0] OP_LW   = 6'd5;
   localparam logic [5:0] OP_SW   = 6'd6;
   localparam logic [5:0] OP_BEQ  = 6'd7;
   localparam logic [5:0] OP_BNE  = 6'd8;
   localparam logic [5:0] OP_LUI  = 6'd9;
   localparam logic [5:0] OP_J    = 6'd10;
   localparam logic [5:0] OP_JAL  = 6'd11;

   // R-type function codes (inst[5:0])
   localparam logic [5:0] FN_AND = 6'd0;
   localparam logic [5:0] FN_OR  = 6'd1;
   localparam logic [5:0] FN_ADD = 6'd2;
   localparam logic [5:0] FN_SUB = 6'd3;
   localparam logic [5:0] FN_SLT = 6'd4;
   localparam logic [5:0] FN_SLL = 6'd5;
   localparam logic [5:0] FN_NOR = 6'd6;
   localparam logic [5:0] FN_JR  = 6'd7;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      MEM  = 2'd2,
      DONE = 2'd3
   } state_t;

   typedef enum logic [2:0] {
      ALU_AND   = 3'd0,
      ALU_OR    = 3'd1,
      ALU_ADD   = 3'd2,
      ALU_SUB   = 3'd3,
      ALU_SLT   = 3'd4,
      ALU_SLL   = 3'd5,
      ALU_NOR   = 3'd6,
      ALU_PASSB = 3'd7
   } alu_op_t;

   typedef struct packed {
      logic [5:0]  opcode;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [4:0]  shamt;
      logic [5:0]  func;
      logic [15:0] imm;
      logic [25:0] addr;
   } dec_t;

   // Split an instruction word into its (overlapping) fields.
   function automatic dec_t decode(input logic [31:0] word);
      dec_t d;
      d.opcode = word[31:26];
      d.rs     = word[25:21];
      d.rt     = word[20:16];
      d.rd     = word[15:11];
      d.shamt  = word[10:6];
      d.func   = word[5:0];
      d.imm    = word[15:0];
      d.addr   = word[25:0];
      return d;
   endfunction

endpackage

// File: rtl/sp_alu.sv
// Combinational ALU for the SP core. The eq flag compares the raw operands
// and is what the branch logic uses.
module sp_alu
   import sp_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [4:0]        shamt,
   input  alu_op_t           op,
   output logic [DATA_W-1:0] result,
   output logic              eq
);

   // Operation select; all arithmetic wraps modulo 2^DATA_W.
   always_comb begin
      result = '0;
      case (op)
         ALU_AND:   result = a & b;
         ALU_OR:    result = a | b;
         ALU_ADD:   result = a + b;
         ALU_SUB:   result = a - b;
         ALU_SLT:   result[0] = ($signed(a) < $signed(b));
         ALU_SLL:   result = a << shamt;
         ALU_NOR:   result = ~(a | b);
         ALU_PASSB: result = b;
         default:   result = '0;
      endcase
   end

   assign eq = (a == b);

endmodule

// File: rtl/sp_multicycle.sv
// Multi-cycle SP core: IDLE -> EXEC -> (MEM) -> DONE -> IDLE.
//
// Handshakes:
//   in_valid/inst  : sampled only in IDLE; one instruction is accepted per
//                    rising edge with in_valid = 1 while IDLE, otherwise ignored.
//   out_valid/err  : one-cycle pulse while in DONE; err is meaningful only
//                    while out_valid = 1.
//   mem_req/mem_ack: mem_req rises on entry to MEM and mem_addr, mem_we and
//                    mem_wdata stay constant until the edge that samples
//                    mem_ack = 1 (mem_rdata is taken on that same edge) or
//                    until MEM_TIMEOUT request cycles pass without an ack.
//                    mem_ack is ignored outside MEM.
module sp_multicycle
   import sp_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int MEM_AW      = 12,
   parameter int MEM_TIMEOUT = 8,
   parameter int R0_ZERO     = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [31:0]       inst,
   output logic              out_valid,
   output logic [31:0]       inst_addr,
   output logic              err,
   output logic              mem_req,
   output logic              mem_we,
   output logic [MEM_AW-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack
);

   localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);
   localparam bit DISCARD_R0 = (R0_ZERO != 0);

   // Architectural state; r stays a plain array so it can be probed by name.
   logic [DATA_W-1:0] r [0:31];
   state_t            state;
   logic [31:0]       inst_q;
   logic [CNT_W-1:0]  wait_cnt;

   dec_t              d;
   logic [DATA_W-1:0] rs_val;
   logic [DATA_W-1:0] rt_val;
   logic [DATA_W-1:0] zext;
   logic [DATA_W-1:0] sext;
   logic [DATA_W-1:0] lui_val;
   logic [31:0]       pc_plus4;
   logic [31:0]       br_target;
   logic [31:0]       jump_target;

   logic [DATA_W-1:0] alu_b;
   alu_op_t           alu_op;
   logic [DATA_W-1:0] alu_res;
   logic              alu_eq;

   logic              wr_en;
   logic [4:0]        wr_idx;
   logic              link;
   logic [DATA_W-1:0] wr_data;
   logic              illegal;
   logic              is_mem;
   logic              is_store;
   logic              is_beq;
   logic              is_bne;
   logic              is_jump;
   logic              is_jr;
   logic [31:0]       next_pc;
   logic              ea_ok;
   logic              wr_allow;
   logic              ld_allow;

   assign d           = decode(inst_q);
   assign rs_val      = r[d.rs];
   assign rt_val      = r[d.rt];
   assign zext        = DATA_W'(d.imm);
   assign sext        = DATA_W'($signed(d.imm));
   assign lui_val     = DATA_W'({d.imm, 16'h0000});
   assign pc_plus4    = inst_addr + 32'd4;
   assign br_target   = pc_plus4 + {{14{d.imm[15]}}, d.imm, 2'b00};
   assign jump_target = {inst_addr[31:28], d.addr, 2'b00};

   sp_alu #(
      .DATA_W(DATA_W)
   ) u_alu (
      .a      (rs_val),
      .b      (alu_b),
      .shamt  (d.shamt),
      .op     (alu_op),
      .result (alu_res),
      .eq     (alu_eq)
   );

   // Decode: ALU operand/op selection, writeback target and instruction class.
   always_comb begin
      alu_b    = rt_val;
      alu_op   = ALU_ADD;
      wr_en    = 1'b0;
      wr_idx   = d.rd;
      link     = 1'b0;
      illegal  = 1'b0;
      is_mem   = 1'b0;
      is_store = 1'b0;
      is_beq   = 1'b0;
      is_bne   = 1'b0;
      is_jump  = 1'b0;
      is_jr    = 1'b0;
      case (d.opcode)
         OP_R: begin
            case (d.func)
               FN_AND: begin alu_op = ALU_AND; wr_en = 1'b1; end
               FN_OR:  begin alu_op = ALU_OR;  wr_en = 1'b1; end
               FN_ADD: begin alu_op = ALU_ADD; wr_en = 1'b1; end
               FN_SUB: begin alu_op = ALU_SUB; wr_en = 1'b1; end
               FN_SLT: begin alu_op = ALU_SLT; wr_en = 1'b1; end
               FN_SLL: begin alu_op = ALU_SLL; wr_en = 1'b1; end
               FN_NOR: begin alu_op = ALU_NOR; wr_en = 1'b1; end
               FN_JR:  is_jr = 1'b1;
               default: illegal = 1'b1;
            endcase
         end
         OP_ANDI: begin alu_b = zext; alu_op = ALU_AND; wr_en = 1'b1; wr_idx = d.rt; end
         OP_ORI:  begin alu_b = zext; alu_op = ALU_OR;  wr_en = 1'b1; wr_idx = d.rt; end
         OP_ADDI: begin alu_b = sext; alu_op = ALU_ADD; wr_en = 1'b1; wr_idx = d.rt; end
         OP_SUBI: begin alu_b = sext; alu_op = ALU_SUB; wr_en = 1'b1; wr_idx = d.rt; end
         OP_LW:   begin alu_b = sext; is_mem = 1'b1; end
         OP_SW:   begin alu_b = sext; is_mem = 1'b1; is_store = 1'b1; end
         OP_BEQ:  is_beq = 1'b1;
         OP_BNE:  is_bne = 1'b1;
         OP_LUI:  begin alu_b = lui_val; alu_op = ALU_PASSB; wr_en = 1'b1; wr_idx = d.rt; end
         OP_J:    is_jump = 1'b1;
         OP_JAL:  begin is_jump = 1'b1; link = 1'b1; wr_en = 1'b1; wr_idx = 5'd31; end
         default: illegal = 1'b1;
      endcase
   end

   // Next PC for instructions that retire from EXEC (branches compare rs/rt).
   always_comb begin
      next_pc = pc_plus4;
      if (is_jr)
         next_pc = rs_val[31:0];
      else if (is_jump)
         next_pc = jump_target;
      else if ((is_beq && alu_eq) || (is_bne && !alu_eq))
         next_pc = br_target;
   end

   assign wr_data  = link ? DATA_W'(pc_plus4) : alu_res;
   // ea is a signed word address: negative or >= 2^MEM_AW both show up as
   // set bits above the memory address field.
   assign ea_ok    = (alu_res[DATA_W-1:MEM_AW] == '0);
   assign wr_allow = !(DISCARD_R0 && (wr_idx == 5'd0));
   assign ld_allow = !(DISCARD_R0 && (d.rt == 5'd0));

   // Control FSM with registered outputs, register file and PC updates.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         inst_q    <= '0;
         wait_cnt  <= '0;
         out_valid <= 1'b0;
         err       <= 1'b0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         inst_addr <= '0;
         for (int i = 0; i < 32; i++) r[i] <= '0;
      end else begin
         case (state)
            IDLE: begin
               out_valid <= 1'b0;
               err       <= 1'b0;
               if (in_valid) begin
                  inst_q <= inst;
                  state  <= EXEC;
               end
            end
            EXEC: begin
               if (is_mem && ea_ok) begin
                  mem_req   <= 1'b1;
                  mem_we    <= is_store;
                  mem_addr  <= alu_res[MEM_AW-1:0];
                  mem_wdata <= rt_val;
                  wait_cnt  <= '0;
                  state     <= MEM;
               end else if (is_mem) begin
                  // Out-of-range access: no request, retire with error.
                  inst_addr <= pc_plus4;
                  err       <= 1'b1;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  if (wr_en && wr_allow) r[wr_idx] <= wr_data;
                  inst_addr <= illegal ? pc_plus4 : next_pc;
                  err       <= illegal;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            MEM: begin
               if (mem_ack) begin
                  if (!mem_we && ld_allow) r[d.rt] <= mem_rdata;
                  mem_req   <= 1'b0;
                  mem_we    <= 1'b0;
                  inst_addr <= pc_plus4;
                  err       <= 1'b0;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else if (wait_cnt == CNT_LAST) begin
                  mem_req   <= 1'b0;
                  mem_we    <= 1'b0;
                  inst_addr <= pc_plus4;
                  err       <= 1'b1;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            DONE: begin
               out_valid <= 1'b0;
               err       <= 1'b0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sp_multicycle.sv
// Directed bench for sp_multicycle: ALU/immediate ops, loads/stores with a
// variable-latency memory responder, range and timeout errors, branches and
// jumps, illegal encodings, ignored in_valid and asynchronous reset.
module tb_sp_multicycle;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [31:0] inst;
   logic        out_valid;
   logic [31:0] inst_addr;
   logic        err;
   logic        mem_req;
   logic        mem_we;
   logic [11:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;

   int checks = 0;
   int errors = 0;

   // scoreboard of expected retirement PCs
   logic [31:0] exp_q[$];
   logic [31:0] pc_model;

   // memory responder configuration (bench-driven) and observations (responder-driven)
   int          ack_delay  = 0;
   bit          respond_en = 1'b1;
   logic [31:0] mem_model [0:4095];
   int          cur_cnt    = 0;
   int          last_len   = 0;
   int          req_total  = 0;
   int          unstable   = 0;
   logic [11:0] cap_addr;
   logic [31:0] cap_wdata;
   logic        cap_we;

   sp_multicycle dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .inst      (inst),
      .out_valid (out_valid),
      .inst_addr (inst_addr),
      .err       (err),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ack   (mem_ack)
   );

   // clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // memory model: acks after ack_delay waiting cycles, watches request stability
   initial begin
      mem_ack   = 1'b0;
      mem_rdata = '0;
      cap_addr  = '0;
      cap_wdata = '0;
      cap_we    = 1'b0;
      forever begin
         @(negedge clk);
         if (mem_req) begin
            cur_cnt++;
            req_total++;
            last_len = cur_cnt;
            if (cur_cnt == 1) begin
               cap_addr  = mem_addr;
               cap_wdata = mem_wdata;
               cap_we    = mem_we;
            end else if (mem_addr !== cap_addr || mem_wdata !== cap_wdata || mem_we !== cap_we) begin
               unstable++;
            end
            if (respond_en && cur_cnt > ack_delay && !mem_ack) begin
               mem_ack = 1'b1;
               if (mem_we) mem_model[mem_addr] = mem_wdata;
               else        mem_rdata = mem_model[mem_addr];
            end else begin
               mem_ack = 1'b0;
            end
         end else begin
            cur_cnt = 0;
            mem_ack = 1'b0;
         end
      end
   end

   // driver: reset pulse
   task automatic apply_reset();
      @(negedge clk);
      rst_n    = 1'b0;
      in_valid = 1'b0;
      inst     = '0;
      repeat (2) @(negedge clk);
      rst_n    = 1'b1;
      pc_model = '0;
   endtask

   // driver: present one instruction, wait (bounded) for retirement.
   // lat = number of edges after the accepting edge until the edge that samples out_valid high.
   task automatic issue(input logic [31:0] word, output int lat, output logic [31:0] pc, output logic e);
      bit done = 1'b0;
      lat = 0;
      pc  = 'x;
      e   = 1'bx;
      @(negedge clk);
      inst     = word;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      inst     = '0;
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge clk);
         if (out_valid) begin
            pc   = inst_addr;
            e    = err;
            lat  = i + 1;
            done = 1'b1;
            @(posedge clk);
         end
      end
   endtask

   task automatic test_reset();
      apply_reset();
      @(negedge clk);
      checks++;
      if ({out_valid, err, mem_req, mem_we} !== 4'b0000) begin
         errors++; $display("FAIL reset_ctrl: got %b exp 0000", {out_valid, err, mem_req, mem_we});
      end
      checks++;
      if (inst_addr !== 32'd0 || mem_addr !== 12'd0 || mem_wdata !== 32'd0) begin
         errors++; $display("FAIL reset_bus: got pc=%h addr=%h wdata=%h exp all 0", inst_addr, mem_addr, mem_wdata);
      end
      checks++;
      if (dut.r[1] !== 32'd0 || dut.r[31] !== 32'd0) begin
         errors++; $display("FAIL reset_regs: got r1=%h r31=%h exp 0", dut.r[1], dut.r[31]);
      end
   endtask

   task automatic test_alu();
      logic [31:0] t_inst [8] = '{32'h0C01FFFD, 32'h0C020005, 32'h00221804, 32'h00412803,
                                   32'h0426FFF0, 32'h24071234, 32'h00404105, 32'h00024806};
      int          t_rd   [8] = '{1, 2, 3, 5, 6, 7, 8, 9};
      logic [31:0] t_val  [8] = '{32'hFFFFFFFD, 32'h00000005, 32'h00000001, 32'h00000008,
                                   32'h0000FFF0, 32'h12340000, 32'h00000050, 32'hFFFFFFFA};
      int lat;
      logic [31:0] pc, exp_pc;
      logic e;
      for (int i = 0; i < 8; i++) begin
         pc_model = pc_model + 32'd4;
         exp_q.push_back(pc_model);
         issue(t_inst[i], lat, pc, e);
         exp_pc = exp_q.pop_front();
         checks++;
         if (lat !== 2) begin errors++; $display("FAIL alu_lat[%0d]: got %0d exp 2", i, lat); end
         checks++;
         if (pc !== exp_pc || e !== 1'b0) begin
            errors++; $display("FAIL alu_retire[%0d]: got pc=%h err=%b exp pc=%h err=0", i, pc, e, exp_pc);
         end
         checks++;
         if (dut.r[t_rd[i]] !== t_val[i]) begin
            errors++; $display("FAIL alu_reg[%0d]: got r%0d=%h exp %h", i, t_rd[i], dut.r[t_rd[i]], t_val[i]);
         end
      end
      // out_valid is a single-cycle pulse
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL pulse_width: got out_valid=%b exp 0", out_valid); end
   endtask

   task automatic test_mem();
      int lat, base_req, base_unst;
      logic [31:0] pc, exp_pc;
      logic e;
      // SW r2,10(r0) acked after 3 wait cycles
      ack_delay = 3;
      base_unst = unstable;
      pc_model  = pc_model + 32'd4;
      exp_q.push_back(pc_model);
      issue(32'h1802000A, lat, pc, e);
      exp_pc = exp_q.pop_front();
      checks++;
      if (lat !== 6) begin errors++; $display("FAIL sw_lat: got %0d exp 6", lat); end
      checks++;
      if (pc !== exp_pc || e !== 1'b0) begin errors++; $display("FAIL sw_retire: got pc=%h err=%b exp pc=%h err=0", pc, e, exp_pc); end
      checks++;
      if (last_len !== 4) begin errors++; $display("FAIL sw_req_len: got %0d exp 4", last_len); end
      checks++;
      if (cap_addr !== 12'd10 || cap_wdata !== 32'd5 || cap_we !== 1'b1) begin
         errors++; $display("FAIL sw_bus: got addr=%0d wdata=%h we=%b exp 10 5 1", cap_addr, cap_wdata, cap_we);
      end
      checks++;
      if (unstable !== base_unst) begin errors++; $display("FAIL sw_stable: got %0d changes exp 0", unstable - base_unst); end
      // LW r4,10(r0) acked immediately
      ack_delay = 0;
      pc_model  = pc_model + 32'd4;
      exp_q.push_back(pc_model);
      issue(32'h1404000A, lat, pc, e);
      exp_pc = exp_q.pop_front();
      checks++;
      if (lat !== 3) begin errors++; $display("FAIL lw_lat: got %0d exp 3", lat); end
      checks++;
      if (pc !== exp_pc || e !== 1'b0 || cap_we !== 1'b0) begin
         errors++; $display("FAIL lw_retire: got pc=%h err=%b we=%b exp pc=%h err=0 we=0", pc, e, cap_we, exp_pc);
      end
      checks++;
      if (dut.r[4] !== 32'd5) begin errors++; $display("FAIL lw_data: got r4=%h exp 5", dut.r[4]); end
      // LW r10,4096(r0) and LW r10,-1(r0): out of range
      for (int i = 0; i < 2; i++) begin
         base_req = req_total;
         pc_model = pc_model + 32'd4;
         exp_q.push_back(pc_model);
         issue((i == 0) ? 32'h140A1000 : 32'h140AFFFF, lat, pc, e);
         exp_pc = exp_q.pop_front();
         checks++;
         if (req_total !== base_req) begin errors++; $display("FAIL oor_req[%0d]: got %0d req cycles exp 0", i, req_total - base_req); end
         checks++;
         if (pc !== exp_pc || e !== 1'b1 || lat !== 2) begin
            errors++; $display("FAIL oor_retire[%0d]: got pc=%h err=%b lat=%0d exp pc=%h err=1 lat=2", i, pc, e, lat, exp_pc);
         end
         checks++;
         if (dut.r[10] !== 32'd0) begin errors++; $display("FAIL oor_reg[%0d]: got r10=%h exp 0", i, dut.r[10]); end
      end
      // LW r11,20(r0) never acked: timeout
      respond_en = 1'b0;
      pc_model   = pc_model + 32'd4;
      exp_q.push_back(pc_model);
      issue(32'h140B0014, lat, pc, e);
      exp_pc = exp_q.pop_front();
      checks++;
      if (lat !== 10 || last_len !== 8) begin
         errors++; $display("FAIL timeout_len: got lat=%0d req=%0d exp lat=10 req=8", lat, last_len);
      end
      checks++;
      if (pc !== exp_pc || e !== 1'b1 || dut.r[11] !== 32'd0) begin
         errors++; $display("FAIL timeout_retire: got pc=%h err=%b r11=%h exp pc=%h err=1 r11=0", pc, e, dut.r[11], exp_pc);
      end
      @(negedge clk);
      checks++;
      if (mem_req !== 1'b0) begin errors++; $display("FAIL timeout_drop: got mem_req=%b exp 0", mem_req); end
      respond_en = 1'b1;
   endtask

   task automatic test_branch();
      logic [31:0] t_inst [10] = '{32'h0C010001, 32'h0C020002, 32'h0C030003, 32'h0C040004,
                                    32'h2022FFFE, 32'h1C220005, 32'h0C050005, 32'h2C000040,
                                    32'h00800007, 32'h1C210003};
      logic [31:0] t_pc   [10] = '{32'd4, 32'd8, 32'd12, 32'd16, 32'd12, 32'd16, 32'd20,
                                    32'h100, 32'd4, 32'd20};
      int lat;
      logic [31:0] pc, exp_pc;
      logic e;
      apply_reset();
      for (int i = 0; i < 10; i++) begin
         exp_q.push_back(t_pc[i]);
         issue(t_inst[i], lat, pc, e);
         exp_pc = exp_q.pop_front();
         checks++;
         if (pc !== exp_pc || e !== 1'b0 || lat !== 2) begin
            errors++; $display("FAIL branch_pc[%0d]: got pc=%h err=%b lat=%0d exp pc=%h err=0 lat=2", i, pc, e, lat, exp_pc);
         end
      end
      pc_model = 32'd20;
      checks++;
      if (dut.r[31] !== 32'd24) begin errors++; $display("FAIL jal_link: got r31=%h exp 24", dut.r[31]); end
   endtask

   task automatic test_illegal();
      logic [31:0] t_inst [3] = '{32'hFC000000, 32'h00223008, 32'h30000000};
      int lat;
      logic [31:0] pc, exp_pc;
      logic e;
      for (int i = 0; i < 3; i++) begin
         pc_model = pc_model + 32'd4;
         exp_q.push_back(pc_model);
         issue(t_inst[i], lat, pc, e);
         exp_pc = exp_q.pop_front();
         checks++;
         if (pc !== exp_pc || e !== 1'b1 || lat !== 2) begin
            errors++; $display("FAIL illegal[%0d]: got pc=%h err=%b lat=%0d exp pc=%h err=1 lat=2", i, pc, e, lat, exp_pc);
         end
      end
      checks++;
      if (dut.r[6] !== 32'd0) begin errors++; $display("FAIL illegal_nowrite: got r6=%h exp 0", dut.r[6]); end
   endtask

   task automatic test_r0_write();
      int lat;
      logic [31:0] pc;
      logic e;
      pc_model = pc_model + 32'd4;
      issue(32'h0C000007, lat, pc, e);
      checks++;
      if (dut.r[0] !== 32'd7 || pc !== pc_model) begin
         errors++; $display("FAIL r0_write: got r0=%h pc=%h exp r0=7 pc=%h", dut.r[0], pc, pc_model);
      end
      pc_model = pc_model + 32'd4;
      issue(32'h0C00FFF9, lat, pc, e);
      checks++;
      if (dut.r[0] !== 32'd0) begin errors++; $display("FAIL r0_restore: got r0=%h exp 0", dut.r[0]); end
   endtask

   task automatic test_in_valid_ignored();
      int lat = 0;
      int extra = 0;
      bit seen = 1'b0;
      logic [31:0] pc = '0;
      // SW r5,3(r0) with 4 wait cycles while in_valid stays high with ADDI r12,r0,9
      ack_delay = 4;
      pc_model  = pc_model + 32'd4;
      @(negedge clk);
      inst     = 32'h18050003;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      inst = 32'h0C0C0009;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (out_valid) begin
            seen = 1'b1;
            lat  = i + 1;
            pc   = inst_addr;
            @(posedge clk);
         end
      end
      @(negedge clk);
      in_valid = 1'b0;
      inst     = '0;
      repeat (5) begin
         @(negedge clk);
         if (out_valid) extra++;
      end
      checks++;
      if (lat !== 7 || pc !== pc_model) begin
         errors++; $display("FAIL busy_retire: got lat=%0d pc=%h exp lat=7 pc=%h", lat, pc, pc_model);
      end
      checks++;
      if (dut.r[12] !== 32'd0 || extra !== 0) begin
         errors++; $display("FAIL busy_ignore: got r12=%h extra=%0d exp 0 0", dut.r[12], extra);
      end
      ack_delay = 0;
   endtask

   task automatic test_reset_mid_mem();
      int lat;
      logic [31:0] pc;
      logic e;
      logic req_before;
      respond_en = 1'b0;
      @(negedge clk);
      inst     = 32'h18050007;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      inst     = '0;
      repeat (3) @(posedge clk);
      #2;
      req_before = mem_req;
      rst_n = 1'b0;
      #1;
      checks++;
      if (req_before !== 1'b1) begin errors++; $display("FAIL midmem_req: got mem_req=%b exp 1", req_before); end
      checks++;
      if ({mem_req, mem_we, out_valid, err} !== 4'b0000 || inst_addr !== 32'd0 || mem_addr !== 12'd0 || mem_wdata !== 32'd0) begin
         errors++; $display("FAIL midmem_reset: got req=%b we=%b ov=%b err=%b pc=%h addr=%h wdata=%h exp all 0",
                            mem_req, mem_we, out_valid, err, inst_addr, mem_addr, mem_wdata);
      end
      checks++;
      if (dut.r[5] !== 32'd0) begin errors++; $display("FAIL midmem_regs: got r5=%h exp 0", dut.r[5]); end
      @(negedge clk);
      rst_n      = 1'b1;
      respond_en = 1'b1;
      pc_model   = 32'd4;
      issue(32'h0C010001, lat, pc, e);
      checks++;
      if (pc !== pc_model || dut.r[1] !== 32'd1 || lat !== 2) begin
         errors++; $display("FAIL post_reset: got pc=%h r1=%h lat=%0d exp pc=4 r1=1 lat=2", pc, dut.r[1], lat);
      end
   endtask

   initial begin
      rst_n    = 1'b0;
      in_valid = 1'b0;
      inst     = '0;
      pc_model = '0;
      test_reset();
      test_alu();
      test_mem();
      test_branch();
      test_illegal();
      test_r0_write();
      test_in_valid_ignored();
      test_reset_mid_mem();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
